// File: rtl/hack_mem_pkg.sv
// Shared Hack memory constants and the RAM arbiter state type.
package hack_mem_pkg;
  localparam int HACK_ADDR_W    = 16;
  localparam int HACK_DATA_W    = 16;
  localparam int HACK_RAM_DEPTH = 32768;

  typedef enum logic [1:0] {
    ARB   = 2'd0,
    LOCK0 = 2'd1,
    LOCK1 = 2'd2
  } arb_state_t;
endpackage

// File: rtl/ram_arb_pick.sv
// Two-way priority picker, one-hot winner output.
// RAM_ARB_RR_EN: tie goes to the port selected by ptr; otherwise port 0 wins ties.
module ram_arb_pick (
  input  logic [1:0] req,
`ifdef RAM_ARB_RR_EN
  input  logic       ptr,
`endif
  output logic [1:0] win
);
`ifdef RAM_ARB_RR_EN
  always_comb begin
    win = req;
    if (&req) win = ptr ? 2'b10 : 2'b01;
  end
`else
  assign win = {req[1] & ~req[0], req[0]};
`endif
endmodule

// File: rtl/ram_arbiter.sv
// Shares the single-ported Hack data RAM between the CPU (port 0) and a secondary master (port 1).
// RAM_ARB_RR_EN selects round-robin tie breaking; default build is fixed priority to port 0.
module ram_arbiter
  import hack_mem_pkg::*;
#(
  parameter int unsigned DEPTH  = HACK_RAM_DEPTH,
  parameter int          ADDR_W = HACK_ADDR_W,
  parameter int          DATA_W = HACK_DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              p0_req,
  input  logic              p0_we,
  input  logic              p0_lock,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [DATA_W-1:0] p0_wdata,
  output logic              p0_gnt,
  output logic              p0_err,
  output logic              p0_rvalid,
  output logic [DATA_W-1:0] p0_rdata,
  input  logic              p1_req,
  input  logic              p1_we,
  input  logic              p1_lock,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [DATA_W-1:0] p1_wdata,
  output logic              p1_gnt,
  output logic              p1_err,
  output logic              p1_rvalid,
  output logic [DATA_W-1:0] p1_rdata,
  output logic [ADDR_W-1:0] ram_address,
  output logic [DATA_W-1:0] ram_in,
  output logic              ram_load,
  input  logic [DATA_W-1:0] ram_out
);
  arb_state_t        state, state_nxt;
  logic [1:0]        pick_win, gnt, rvalid;
  logic [ADDR_W-1:0] last_addr, win_addr;
  logic [DATA_W-1:0] win_wdata;
  logic              win_we, in_range, any_gnt;

`ifdef RAM_ARB_RR_EN
  logic ptr;
  ram_arb_pick u_pick (.req({p1_req, p0_req}), .ptr(ptr), .win(pick_win));

  // Pointer toggles on every grant issued from ARB; locked grants leave it alone.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                    ptr <= 1'b0;
    else if (state == ARB && any_gnt) ptr <= ~ptr;
  end
`else
  ram_arb_pick u_pick (.req({p1_req, p0_req}), .win(pick_win));
`endif

  always_comb begin
    gnt       = 2'b00;
    state_nxt = state;
    case (state)
      ARB: begin
        gnt = pick_win;
        if (pick_win[0] && p0_lock)      state_nxt = LOCK0;
        else if (pick_win[1] && p1_lock) state_nxt = LOCK1;
      end
      LOCK0: begin
        gnt[0] = p0_req;
        if (!p0_req || !p0_lock) state_nxt = ARB;
      end
      LOCK1: begin
        gnt[1] = p1_req;
        if (!p1_req || !p1_lock) state_nxt = ARB;
      end
      default: state_nxt = ARB;
    endcase
    // Keep the RAM and requesters quiet while reset is held.
    if (reset) gnt = 2'b00;
  end

  assign any_gnt   = |gnt;
  assign win_addr  = gnt[1] ? p1_addr  : p0_addr;
  assign win_wdata = gnt[1] ? p1_wdata : p0_wdata;
  assign win_we    = gnt[1] ? p1_we    : p0_we;
  assign in_range  = {{(32-ADDR_W){1'b0}}, win_addr} < DEPTH;

  assign p0_gnt = gnt[0];
  assign p1_gnt = gnt[1];
  assign p0_err = gnt[0] & ~in_range;
  assign p1_err = gnt[1] & ~in_range;

  assign ram_address = any_gnt ? win_addr : last_addr;
  assign ram_in      = win_wdata;
  assign ram_load    = any_gnt & win_we & in_range;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ARB;
      last_addr <= '0;
      rvalid    <= 2'b00;
    end else begin
      state     <= state_nxt;
      last_addr <= ram_address;
      rvalid    <= gnt & {2{~win_we & in_range}};
    end
  end

  assign p0_rvalid = rvalid[0];
  assign p1_rvalid = rvalid[1];
  assign p0_rdata  = rvalid[0] ? ram_out : '0;
  assign p1_rdata  = rvalid[1] ? ram_out : '0;
endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: behavioural RAM, shadow-memory reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic with occasional resets.
module tb_ram_arbiter;
  localparam int DEPTH = 32768;

  logic        clk = 1'b0;
  logic        reset;
  logic        req[2], we[2], lock[2];
  logic [15:0] addr[2], wdata[2];
  logic        p0_gnt, p0_err, p0_rvalid, p1_gnt, p1_err, p1_rvalid;
  logic [15:0] p0_rdata, p1_rdata, ram_address, ram_in, ram_out;
  logic        ram_load;

  ram_arbiter dut (
    .clk(clk), .reset(reset),
    .p0_req(req[0]), .p0_we(we[0]), .p0_lock(lock[0]), .p0_addr(addr[0]), .p0_wdata(wdata[0]),
    .p0_gnt(p0_gnt), .p0_err(p0_err), .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata),
    .p1_req(req[1]), .p1_we(we[1]), .p1_lock(lock[1]), .p1_addr(addr[1]), .p1_wdata(wdata[1]),
    .p1_gnt(p1_gnt), .p1_err(p1_err), .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata),
    .ram_address(ram_address), .ram_in(ram_in), .ram_load(ram_load), .ram_out(ram_out)
  );

  always #5 clk = ~clk;

  // Behavioural single-port RAM; only 15 address bits decode, so unguarded high addresses alias.
  logic [15:0] mem[DEPTH];
  always @(posedge clk) begin
    if (ram_load) mem[ram_address[14:0]] <= ram_in;
    ram_out <= mem[ram_address[14:0]];
  end

  int n_cmp = 0, n_bad = 0;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model state
  logic [15:0] shadow[DEPTH];
  int          owner;
  bit          ptr;
  bit          pend[2];
  logic [15:0] pdata[2];
  logic [15:0] last;

  // Snapshots of the last sampled cycle for literal checks
  logic        s_gnt[2], s_err[2], s_rv[2], s_load;
  logic [15:0] s_rd[2], s_addr;

  task automatic model_check();
    bit          w[2];
    bit          any, inr, el;
    int          k;
    logic [15:0] wa, ea;
    s_gnt[0] = p0_gnt;  s_gnt[1] = p1_gnt;  s_err[0] = p0_err;  s_err[1] = p1_err;
    s_rv[0]  = p0_rvalid; s_rv[1] = p1_rvalid; s_rd[0] = p0_rdata; s_rd[1] = p1_rdata;
    s_load   = ram_load; s_addr = ram_address;
    if (reset) begin
      chk("rst_gnt0", p0_gnt, 0);   chk("rst_gnt1", p1_gnt, 0);
      chk("rst_err0", p0_err, 0);   chk("rst_err1", p1_err, 0);
      chk("rst_rv0", p0_rvalid, 0); chk("rst_rv1", p1_rvalid, 0);
      chk("rst_load", ram_load, 0); chk("rst_addr", ram_address, 0);
      owner = -1; ptr = 0; pend[0] = 0; pend[1] = 0; last = 16'h0;
      return;
    end
    chk("rvalid0", p0_rvalid, pend[0]);
    chk("rvalid1", p1_rvalid, pend[1]);
    chk("rdata0", p0_rdata, pend[0] ? pdata[0] : 16'h0);
    chk("rdata1", p1_rdata, pend[1] ? pdata[1] : 16'h0);
    w[0] = 0; w[1] = 0;
    if (owner < 0) begin
      if (req[0] && req[1]) begin
`ifdef RAM_ARB_RR_EN
        w[ptr] = 1;
`else
        w[0] = 1;
`endif
      end else begin
        w[0] = req[0]; w[1] = req[1];
      end
    end else w[owner] = req[owner];
    any = w[0] | w[1];
    k   = w[1] ? 1 : 0;
    wa  = addr[k];
    inr = int'(wa) < DEPTH;
    ea  = any ? wa : last;
    el  = any && we[k] && inr;
    chk("gnt0", p0_gnt, w[0]);
    chk("gnt1", p1_gnt, w[1]);
    chk("err0", p0_err, w[0] && !inr);
    chk("err1", p1_err, w[1] && !inr);
    chk("ram_load", ram_load, el);
    chk("ram_address", ram_address, ea);
    if (el) chk("ram_in", ram_in, wdata[k]);
    for (int p = 0; p < 2; p++) begin
      pend[p]  = w[p] && !we[p] && inr;
      pdata[p] = shadow[wa[14:0]];
    end
    if (el) shadow[wa[14:0]] = wdata[k];
    if (owner < 0) begin
      if (any && lock[k]) owner = k;
`ifdef RAM_ARB_RR_EN
      if (any) ptr = ~ptr;
`endif
    end else if (!req[owner] || !lock[owner]) owner = -1;
    last = ea;
  endtask

  // Sample at negedge, then return just after the next posedge so inputs can change.
  task automatic tick();
    @(negedge clk);
    model_check();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(int p, bit r, bit w, bit l, logic [15:0] a, logic [15:0] d);
    req[p] = r; we[p] = w; lock[p] = l; addr[p] = a; wdata[p] = d;
  endtask

  bit g0seq[4], g1seq[4];

  initial begin
    for (int i = 0; i < DEPTH; i++) begin mem[i] = 16'h0; shadow[i] = 16'h0; end
    owner = -1; ptr = 0; pend[0] = 0; pend[1] = 0; last = 0;
    reset = 1;
    set_req(0, 1, 0, 0, 16'd3, 16'h0);
    set_req(1, 0, 0, 0, 16'd0, 16'h0);
    tick();
    chk("lit_rst_gnt0", s_gnt[0], 0);
    chk("lit_rst_addr", s_addr, 0);

    // Reset during a read: the pending rvalid must be dropped
    reset = 0;
    tick();
    chk("lit_rd3_gnt0", s_gnt[0], 1);
    reset = 1; req[0] = 0;
    tick();
    chk("lit_midrst_rv0", s_rv[0], 0);
    chk("lit_midrst_load", s_load, 0);
    reset = 0;
    set_req(1, 1, 0, 0, 16'd4, 16'h0);
    tick();
    chk("lit_postrst_gnt1", s_gnt[1], 1);
    req[1] = 0;

    // Single-port write/read round trip
    set_req(0, 1, 1, 0, 16'd5, 16'h1234);
    tick();
    chk("lit_wr5_gnt0", s_gnt[0], 1);
    chk("lit_wr5_load", s_load, 1);
    set_req(0, 1, 0, 0, 16'd5, 16'h0);
    tick();
    chk("lit_rd5_gnt0", s_gnt[0], 1);
    req[0] = 0;
    tick();
    chk("lit_rd5_rv0", s_rv[0], 1);
    chk("lit_rd5_data", s_rd[0], 16'h1234);

    // Both ports reading every cycle, from a fresh reset
    reset = 1; tick(); reset = 0;
    set_req(0, 1, 0, 0, 16'd10, 16'h0);
    set_req(1, 1, 0, 0, 16'd11, 16'h0);
    for (int i = 0; i < 4; i++) begin
      tick();
      g0seq[i] = s_gnt[0]; g1seq[i] = s_gnt[1];
    end
`ifdef RAM_ARB_RR_EN
    chk("lit_tie_order", {g0seq[0], g0seq[1], g0seq[2], g0seq[3]}, 4'b1010);
    chk("lit_tie_order1", {g1seq[0], g1seq[1], g1seq[2], g1seq[3]}, 4'b0101);
`else
    chk("lit_tie_p0", {g0seq[0], g0seq[1], g0seq[2], g0seq[3]}, 4'b1111);
    chk("lit_tie_p1", {g1seq[0], g1seq[1], g1seq[2], g1seq[3]}, 4'b0000);
`endif
    req[0] = 0; req[1] = 0;
    tick();

    // Lock: p1 holds the RAM for three writes, p0 waits
    set_req(1, 1, 1, 1, 16'd100, 16'd1);
    tick();
    chk("lit_lock_g1a", s_gnt[1], 1);
    set_req(1, 1, 1, 1, 16'd101, 16'd2);
    set_req(0, 1, 0, 0, 16'd100, 16'h0);
    tick();
    chk("lit_lock_g1b", s_gnt[1], 1);
    chk("lit_lock_g0b", s_gnt[0], 0);
    set_req(1, 1, 1, 0, 16'd102, 16'd3);
    tick();
    chk("lit_lock_g1c", s_gnt[1], 1);
    chk("lit_lock_g0c", s_gnt[0], 0);
    req[1] = 0;
    tick();
    chk("lit_lock_release", s_gnt[0], 1);
    addr[0] = 16'd101;
    tick();
    chk("lit_lock_rd100", s_rd[0], 16'd1);
    addr[0] = 16'd102;
    tick();
    chk("lit_lock_rd101", s_rd[0], 16'd2);
    req[0] = 0;
    tick();
    chk("lit_lock_rd102", s_rd[0], 16'd3);

    // Write then read of the same address from the other port
    set_req(0, 1, 1, 0, 16'd0, 16'd7);
    tick();
    req[0] = 0;
    set_req(1, 1, 0, 0, 16'd0, 16'h0);
    tick();
    req[1] = 0;
    tick();
    chk("lit_hazard_rv1", s_rv[1], 1);
    chk("lit_hazard_rd1", s_rd[1], 16'd7);

    // Out-of-range accesses: granted with err, no RAM write, no rvalid
    set_req(0, 1, 1, 0, 16'h8000, 16'hBEEF);
    tick();
    chk("lit_oor_gnt", s_gnt[0], 1);
    chk("lit_oor_err", s_err[0], 1);
    chk("lit_oor_load", s_load, 0);
    set_req(0, 1, 0, 0, 16'h8000, 16'h0);
    tick();
    chk("lit_oorrd_err", s_err[0], 1);
    set_req(0, 1, 0, 0, 16'd0, 16'h0);
    tick();
    chk("lit_oor_no_rv", s_rv[0], 0);
    req[0] = 0;
    tick();
    chk("lit_oor_mem0", s_rd[0], 16'd7);

    // Randomized traffic; requests are held until granted
    for (int c = 0; c < 3000; c++) begin
      reset = ($urandom_range(0, 299) == 0);
      for (int p = 0; p < 2; p++) begin
        if (!req[p] || s_gnt[p]) begin
          if ($urandom_range(0, 3) != 0) begin
            req[p]   = 1;
            we[p]    = 1'($urandom_range(0, 1));
            addr[p]  = ($urandom_range(0, 15) == 0) ? (16'h8000 | 16'($urandom_range(0, 31)))
                                                    : 16'($urandom_range(0, 31));
            wdata[p] = 16'($urandom);
          end else req[p] = 0;
        end
        lock[p] = ($urandom_range(0, 2) == 0);
      end
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
